// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, datapath width and the execute-stage state encoding.
package alu_pkg;

  localparam int unsigned ALU_XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_MUL  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_AND  = 4'b1001;
  localparam logic [3:0] ALU_OR   = 4'b1010;
  localparam logic [3:0] ALU_XOR  = 4'b1011;
  localparam logic [3:0] ALU_SLTU = 4'b1100;
  localparam logic [3:0] ALU_SLT  = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU operations; MUL and unlisted codes produce zero here.
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = ALU_XLEN
) (
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result_c
);

  localparam int unsigned SHAMT_W = $clog2(XLEN);

  logic [SHAMT_W-1:0] shamt;

  assign shamt = b[SHAMT_W-1:0];

  always_comb begin
    result_c = '0;
    case (alu_op)
      ALU_ADD:  result_c = a + b;
      ALU_SUB:  result_c = a - b;
      ALU_SLL:  result_c = a << shamt;
      ALU_SRL:  result_c = a >> shamt;
      ALU_SRA:  result_c = $unsigned($signed(a) >>> shamt);
      ALU_AND:  result_c = a & b;
      ALU_OR:   result_c = a | b;
      ALU_XOR:  result_c = a ^ b;
      ALU_SLTU: result_c = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_SLT:  result_c = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default:  result_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake; single-cycle ops via alu_comb,
// MUL via an iterative shift-add multiplier consuming MUL_STEP bits per cycle.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN     = ALU_XLEN,
  parameter int unsigned MUL_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            out_zero
);

  localparam int unsigned ITER  = XLEN / MUL_STEP;
  localparam int unsigned CNT_W = $clog2(ITER);

  alu_state_e        state_q, state_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   a_sh_q, a_sh_d;
  logic [XLEN-1:0]   b_sh_q, b_sh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d;
  logic [XLEN-1:0]   comb_res_c;
  logic [XLEN-1:0]   pp_c;
  logic              accept_c;

  alu_comb #(.XLEN(XLEN)) u_comb (
    .alu_op   (alu_op),
    .a        (a),
    .b        (b),
    .result_c (comb_res_c)
  );

  // A stalled DONE blocks new work; a consumed DONE can take the next op in the same cycle.
  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept_c  = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign out_zero  = zero_q;
  assign pp_c      = a_sh_q * XLEN'(b_sh_q[MUL_STEP-1:0]);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if ((state_q == ST_DONE) && out_ready) begin
          state_d  = ST_IDLE;
          result_d = '0;
          zero_d   = 1'b0;
        end
        if (accept_c) begin
          if (alu_op == ALU_MUL) begin
            state_d  = ST_MUL;
            acc_d    = '0;
            a_sh_d   = a;
            b_sh_d   = b;
            cnt_d    = '0;
            result_d = '0;
            zero_d   = 1'b0;
          end else begin
            state_d  = ST_DONE;
            result_d = comb_res_c;
            zero_d   = (comb_res_c == '0);
          end
        end
      end
      ST_MUL: begin
        acc_d  = acc_q + pp_c;
        a_sh_d = a_sh_q << MUL_STEP;
        b_sh_d = b_sh_q >> MUL_STEP;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITER - 1)) begin
          state_d  = ST_DONE;
          result_d = acc_d;
          zero_d   = (acc_d == '0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus randomized ops against a reference model.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [3:0]  alu_op;
  logic [31:0] a, b, result;
  logic        in_valid4, in_ready4, out_valid4, out_zero4;
  logic [31:0] result4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(32), .MUL_STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_zero(out_zero)
  );

  alu_exec_unit #(.XLEN(32), .MUL_STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .alu_op(alu_op), .a(a), .b(b), .out_valid(out_valid4), .out_ready(1'b1),
    .result(result4), .out_zero(out_zero4)
  );

  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] prod;
    int          sx, sy;
    int unsigned s;
    s = int'(y[4:0]);
    sx = x;
    sy = y;
    case (op)
      ALU_ADD:  return x + y;
      ALU_SUB:  return x - y;
      ALU_MUL:  begin prod = {32'd0, x} * {32'd0, y}; return prod[31:0]; end
      ALU_SLL:  return x << s;
      ALU_SRL:  return x >> s;
      ALU_SRA:  return (x >> s) | (x[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
      ALU_AND:  return x & y;
      ALU_OR:   return x | y;
      ALU_XOR:  return x ^ y;
      ALU_SLTU: return (x < y) ? 32'd1 : 32'd0;
      ALU_SLT:  return (sx < sy) ? 32'd1 : 32'd0;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input int step);
    return (op == ALU_MUL) ? (32 / step + 1) : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op on dut, optionally hold out_ready low for `stall` cycles once the result appears.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        input int stall);
    logic [31:0] exp_res;
    int          exp_lat, lat, busy;
    logic        stable;
    exp_res = ref_result(op, x, y);
    exp_lat = ref_latency(op, 1);
    out_ready = (stall == 0);
    in_valid = 1'b1;
    alu_op = op;
    a = x;
    b = y;
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    alu_op = 4'($urandom);
    a = $urandom;
    b = $urandom;
    lat = 1;
    busy = 0;
    while (!out_valid && lat < 200) begin
      if (!in_ready) busy++;
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, 32'(busy), 32'(exp_lat - 1));
    check({tag, "_result"}, result, exp_res);
    check({tag, "_zero"}, 32'(out_zero), 32'(exp_res == 32'd0));
    stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      tick();
      if (!out_valid || in_ready || result !== exp_res) stable = 1'b0;
    end
    if (stall > 0) check({tag, "_stall_hold"}, 32'(stable), 32'd1);
    out_ready = 1'b1;
    tick();
    check({tag, "_drained"}, {31'd0, out_valid} | result, 32'd0);
  endtask

  initial begin
    logic [31:0] exp_x;
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    int          lat4;
    logic        stable;

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_valid4 = 1'b0;
    out_ready = 1'b1;
    alu_op = 4'd0;
    a = 32'd0;
    b = 32'd0;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(out_zero), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_in_ready4", 32'(in_ready4), 32'd1);

    run_op("add_5_7", ALU_ADD, 32'd5, 32'd7, 0);
    run_op("slt_neg", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("sltu_big", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("sra_4", ALU_SRA, 32'h8000_0000, 32'h0000_0024, 0);
    run_op("sub_zero", ALU_SUB, 32'd9, 32'd9, 0);
    run_op("mul_step1", ALU_MUL, 32'hFFFF_FFFF, 32'd3, 0);
    run_op("undef_1110", 4'b1110, 32'd3, 32'd4, 0);
    run_op("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("sll_31", ALU_SLL, 32'd1, 32'hFFFF_FFFF, 0);

    // MUL_STEP=4 instance: 8 iterations plus the accept cycle.
    alu_op = ALU_MUL;
    a = 32'hFFFF_FFFF;
    b = 32'd3;
    in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    a = $urandom;
    lat4 = 1;
    while (!out_valid4 && lat4 < 100) begin
      tick();
      lat4++;
    end
    check("mul4_latency", 32'(lat4), 32'd9);
    check("mul4_result", result4, 32'hFFFF_FFFD);
    check("mul4_zero", 32'(out_zero4), 32'd0);
    tick();
    check("mul4_drained", 32'(out_valid4), 32'd0);

    // Backpressure, then consume-and-accept in the same cycle.
    exp_x = ref_result(ALU_XOR, 32'h1234_5678, 32'h0F0F_0F0F);
    out_ready = 1'b0;
    in_valid = 1'b1;
    alu_op = ALU_XOR;
    a = 32'h1234_5678;
    b = 32'h0F0F_0F0F;
    tick();
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_result", result, exp_x);
    alu_op = ALU_OR;
    a = 32'h0000_000F;
    b = 32'h0000_00F0;
    stable = 1'b1;
    repeat (5) begin
      tick();
      if (!out_valid || in_ready || result !== exp_x) stable = 1'b0;
    end
    check("bp_stable", 32'(stable), 32'd1);
    out_ready = 1'b1;
    #1;
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("b2b_valid", 32'(out_valid), 32'd1);
    check("b2b_result", result, 32'h0000_00FF);
    tick();
    check("b2b_drained", 32'(out_valid), 32'd0);

    // Reset in the middle of a MUL.
    in_valid = 1'b1;
    alu_op = ALU_MUL;
    a = 32'h0001_2345;
    b = 32'h0000_0777;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    check("midmul_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    tick();
    check("midmul_rst_valid", 32'(out_valid), 32'd0);
    check("midmul_rst_result", result, 32'd0);
    check("midmul_rst_zero", 32'(out_zero), 32'd0);
    check("midmul_rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();
    run_op("post_rst_add", ALU_ADD, 32'd1, 32'd1, 0);

    // Randomized ops with random output stalls.
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : 32'($urandom);
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 40));
      run_op($sformatf("rand%0d_op%0h", i, rop), rop, ra, rb, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
